// File: rtl/kmap_response_checker.sv
// kmap_response_checker
// Monitors the output side of a 4-input combinational Karnaugh-map block. Each
// applied vector {A3,A2,A1,A0} and its response Z is sampled once it has been
// stable for SETTLE edges. The samples build an observed truth table, and
// inconsistent repeats are flagged. When all 16 minterms are covered, the table
// is graded against EXPECTED.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   clr           : synchronous clear (same effect as rst)
//   A0..A3, Z     : applied vector and observed response
//   sample_valid  : one-cycle pulse per accepted sample
//   table_out     : observed truth table (bit i = Z sampled for vector i)
//   seen          : bit i set once vector i has been sampled
//   conflict      : sticky, a vector was re-sampled with a different Z
//   done          : all 16 vectors covered
//   pass          : table matches EXPECTED with no conflict (valid while done)
//   mismatch_cnt  : number of minterms differing from EXPECTED (valid while done)
module kmap_response_checker #(
    parameter logic [15:0] EXPECTED = 16'h6996,
    parameter int unsigned SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        A0,
    input  logic        A1,
    input  logic        A2,
    input  logic        A3,
    input  logic        Z,
    output logic        sample_valid,
    output logic [15:0] table_out,
    output logic [15:0] seen,
    output logic        conflict,
    output logic        done,
    output logic        pass,
    output logic [4:0]  mismatch_cnt
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OBS_W  = 5;
    localparam int unsigned MM_W   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] FIRE_CNT  = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [OBS_W-1:0] prev;
    logic [CNT_W-1:0] stab_cnt;
    logic             sample_armed;

    logic [OBS_W-1:0] obs;
    logic [3:0]       vec;
    logic             obs_same;
    logic             fire;
    logic [MM_W-1:0]  mm_now;

    // Count of set bits in a 16-bit word.
    function automatic logic [MM_W-1:0] popcount16(input logic [15:0] x);
        logic [MM_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + MM_W'(x[i]);
        end
        return cnt;
    endfunction

    assign obs      = {A3, A2, A1, A0, Z};
    assign vec      = obs[4:1];
    assign obs_same = (obs == prev);
    // Fire once per stable run, on the edge completing SETTLE unchanged edges.
    assign fire     = obs_same && sample_armed && (stab_cnt == FIRE_CNT);
    assign mm_now   = popcount16(table_out ^ EXPECTED);

    // State, stability tracking, table build-up and grading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            prev         <= '0;
            stab_cnt     <= '0;
            sample_armed <= 1'b1;
            sample_valid <= 1'b0;
            table_out    <= '0;
            seen         <= '0;
            conflict     <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
        end else if (clr) begin
            state        <= IDLE;
            prev         <= '0;
            stab_cnt     <= '0;
            sample_armed <= 1'b1;
            sample_valid <= 1'b0;
            table_out    <= '0;
            seen         <= '0;
            conflict     <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            prev         <= obs;
            sample_valid <= fire;

            if (!obs_same) begin
                stab_cnt     <= '0;
                sample_armed <= 1'b1;
            end else begin
                if (stab_cnt != CNT_MAX) begin
                    stab_cnt <= stab_cnt + CNT_W'(1);
                end
                if (fire) begin
                    sample_armed <= 1'b0;
                end
            end

            // First sample of a vector defines its table entry; later ones only check it.
            if (fire) begin
                if (!seen[vec]) begin
                    seen[vec]      <= 1'b1;
                    table_out[vec] <= obs[0];
                end else if (table_out[vec] != obs[0]) begin
                    conflict <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (fire) begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (seen == 16'hFFFF) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        mismatch_cnt <= mm_now;
                        pass         <= (mm_now == '0) && !conflict;
                    end
                end
                DONE: begin
                    // Late conflicts still revoke a pass; grading is otherwise frozen.
                    if (conflict) begin
                        pass <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/kmap_response_checker.md
Name: kmap_response_checker

Overview:
- Synthesizable monitor on the output side of a 4-input combinational Karnaugh-map block.
- Watches the applied vector {A3,A2,A1,A0} and the block's response Z.
- Samples each vector once it is stable and builds the observed 16-entry truth table.
- Flags inconsistent responses and, once all 16 minterms are covered, compares the table against an expected truth table and reports pass/fail and the number of mismatching minterms.

Parameters:
- EXPECTED, 16'h6996, expected truth table; bit i = required Z for vector i (i = {A3,A2,A1,A0}).
- SETTLE, 2, number of consecutive rising edges {vector,Z} must be unchanged before it is sampled (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear; same effect as rst, one cycle later.
- A0  input  1  vector bit 0, synchronous to clk.
- A1  input  1  vector bit 1.
- A2  input  1  vector bit 2.
- A3  input  1  vector bit 3.
- Z  input  1  response of the block under observation.
- sample_valid  output  1  one-cycle pulse per accepted sample.
- table_out  output  16  observed truth table; bit i = sampled Z for vector i.
- seen  output  16  bit i set once vector i has been sampled.
- conflict  output  1  sticky; same vector sampled with a different Z.
- done  output  1  all 16 vectors covered.
- pass  output  1  valid while done=1: table_out==EXPECTED and conflict=0.
- mismatch_cnt  output  5  popcount(table_out ^ EXPECTED), valid while done=1 (0..16).

Behaviour:
- Reset (rst high, async) or clr (sync): all outputs 0, stability counter 0, prev registers 0, sample_armed 1, state IDLE. clr has priority over any same-cycle sample.
- Stability tracking:
  - prev = registered {A3,A2,A1,A0,Z}.
  - If the current {vector,Z} differs from prev: stab_cnt ← 0 and re-arm.
  - Otherwise stab_cnt increments, saturating at 15.
  - A sample fires on the edge where the value has been present for SETTLE consecutive edges (stab_cnt == SETTLE-1 and input equals prev) and sample_armed=1. It then disarms, so there is exactly one sample per stable run.
  - With SETTLE=1, any vector present at an edge immediately after a change is sampled.
- Sample effect, on the same edge that asserts sample_valid:
  - If seen[v]=0: seen[v] ← 1 and table_out[v] ← Z.
  - If seen[v]=1 and table_out[v] != Z: conflict ← 1; table_out keeps the first value.
  - If seen[v]=1 and table_out[v] == Z: no change.
- FSM:
  - IDLE → COLLECT on the first sample.
  - COLLECT → DONE on the edge after seen becomes 16'hFFFF. On that edge done ← 1, mismatch_cnt ← popcount(table_out ^ EXPECTED), and pass ← (mismatch_cnt==0) && !conflict.
  - DONE holds until rst or clr. Samples are still processed in DONE; a new conflict clears pass on the following edge. table_out and mismatch_cnt are frozen in DONE.
- Input glitches shorter than SETTLE edges are never sampled.
- Re-applying the same vector after a different one is a new stable run and is sampled again (repeat/conflict check).
- rst mid-sweep discards all coverage; the sweep restarts from empty.

Test Plan:
1. Reset with inputs toggling → all outputs 0; no sample_valid while rst=1; first sample only SETTLE edges after rst deasserts.
2. Sweep vectors 0..15, each held 4 cycles, Z = parity(vector) → 16 sample_valid pulses, seen=16'hFFFF, table_out=16'h6996, then done=1, pass=1, mismatch_cnt=0, conflict=0.
3. Same sweep but Z=1 for vector 6 and Z=1 for vector 9 → table_out=16'h6BD6, done=1, pass=0, mismatch_cnt=2.
4. Vector 4'b0110 held 1 cycle between stable vectors (SETTLE=2) → no sample for 6, seen[6]=0; then hold 6 for 3 cycles → exactly one sample_valid, seen[6]=1.
5. Apply 6 with Z=0, then 9 with Z=0, then 6 with Z=1, each 4 cycles → conflict=1 after the third sample, table_out[6]=0, seen has only bits 6 and 9 set.
6. Full correct sweep to done=1, then pulse clr for 1 cycle → next edge all outputs 0, state IDLE. Separately, assert rst asynchronously after 5 vectors → outputs clear immediately without a clock edge; a subsequent full sweep ends with pass=1.
